// File: rtl/button_pulser_pkg.sv
// button_pulser_pkg: edge-mode selectors and per-channel debounce state encoding.
// Bit 1 of the state is the debounced level and bit 0 marks a pending change.
package button_pulser_pkg;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'b00,
    LOW_WAIT    = 2'b01,
    HIGH_STABLE = 2'b10,
    HIGH_WAIT   = 2'b11
  } pulser_state_e;

  function automatic logic edge_match(input int mode, input logic rising);
    return mode == EDGE_BOTH || (rising ? mode == EDGE_RISE : mode == EDGE_FALL);
  endfunction
endpackage

// File: rtl/pulser_channel.sv
// pulser_channel: one input's synchroniser, debounce FSM, edge pulse and,
// with BUTTON_PULSER_REPEAT_EN defined, hold-to-repeat pulses while held high.
module pulser_channel
  import button_pulser_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int EDGE_MODE       = EDGE_RISE
`ifdef BUTTON_PULSER_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_PERIOD   = 10000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  pulser_state_e state_q, state_d;
  logic pulse_q, pulse_d;
  logic mismatch, done, edge_pulse, rep_fire;

  assign level = state_q[1];
  assign pulse = pulse_q;

  // Any cycle where the synchronised input agrees with the level restarts the count.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    mismatch = sync_q[SYNC_STAGES-1] ^ level;
    done = mismatch && cnt_q == CNT_LAST;
    cnt_d = mismatch && !done ? cnt_q + 1'b1 : '0;
    state_d = done ? (level ? LOW_STABLE : HIGH_STABLE)
            : level ? (mismatch ? HIGH_WAIT : HIGH_STABLE)
            : (mismatch ? LOW_WAIT : LOW_STABLE);
    edge_pulse = done && edge_match(EDGE_MODE, !level);
  end

  assign pulse_d = edge_pulse || rep_fire;

`ifdef BUTTON_PULSER_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(RMAX + 1);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic rep_q, rep_d, stay_high;

  // rep_q switches the hold target from the initial delay to the repeat period.
  always_comb begin
    stay_high = state_q == HIGH_STABLE && !mismatch;
    rep_fire = EDGE_MODE != EDGE_FALL && stay_high
             && hold_q == (rep_q ? PERIOD_LAST : DELAY_LAST);
    hold_d = stay_high && !rep_fire ? hold_q + 1'b1 : '0;
    rep_d = stay_high && (rep_q || rep_fire);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= LOW_STABLE;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      pulse_q <= pulse_d;
    end
endmodule

// File: rtl/button_pulser.sv
// button_pulser: independent debounced level and single-cycle edge pulse per raw input.
// Define BUTTON_PULSER_REPEAT_EN to add hold-to-repeat pulses on held channels.
module button_pulser
  import button_pulser_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int EDGE_MODE       = EDGE_RISE,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_PERIOD   = 10000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] DataIn,
  output logic [CHANNELS-1:0] DataOut,
  output logic [CHANNELS-1:0] Level
);
  if (CHANNELS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || EDGE_MODE < EDGE_RISE
      || EDGE_MODE > EDGE_BOTH || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_pulser: unsupported parameter combination");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pulser_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_MODE      (EDGE_MODE)
`ifdef BUTTON_PULSER_REPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk  (Clk),
      .rst_n(Reset),
      .din  (DataIn[i]),
      .pulse(DataOut[i]),
      .level(Level[i])
    );
  end
endmodule

// File: tb/tb_button_pulser.sv
// tb_button_pulser: scoreboard bench driving a rising-edge and a both-edge instance from shared inputs.
module tb_button_pulser;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic [1:0] DataIn = 2'b00;
  logic [1:0] out_a, lvl_a, out_b, lvl_b;

  typedef struct packed {
    logic [1:0] out_a;
    logic [1:0] lvl_a;
    logic [1:0] out_b;
    logic [1:0] lvl_b;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  button_pulser #(
    .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0),
    .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut_a (
    .Clk(Clk), .Reset(Reset), .DataIn(DataIn), .DataOut(out_a), .Level(lvl_a)
  );

  button_pulser #(
    .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2),
    .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut_b (
    .Clk(Clk), .Reset(Reset), .DataIn(DataIn), .DataOut(out_b), .Level(lvl_b)
  );

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] oa, input logic [1:0] la,
                          input logic [1:0] ob, input logic [1:0] lb);
    exp_t e;
    e.out_a = oa;
    e.lvl_a = la;
    e.out_b = ob;
    e.lvl_b = lb;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    exp_t e;
    Reset = 1'b0;
    DataIn = 2'b00;
    repeat (2) step;
    push_exp(2'b00, 2'b00, 2'b00, 2'b00);
    e = sb.pop_front();
    vectors++;
    if ({out_a, lvl_a, out_b, lvl_b} !== e) begin
      miscompares++;
      $display("FAIL reset_state: got %b %b %b %b, expected %b %b %b %b",
               out_a, lvl_a, out_b, lvl_b, e.out_a, e.lvl_a, e.out_b, e.lvl_b);
    end
    Reset = 1'b1;
    for (int i = 1; i <= 4; i++) push_exp(2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 1; i <= 4; i++) begin
      step;
      e = sb.pop_front();
      vectors++;
      if ({out_a, lvl_a, out_b, lvl_b} !== e) begin
        miscompares++;
        $display("FAIL reset_idle edge %0d: got %b %b %b %b, expected %b %b %b %b", i,
                 out_a, lvl_a, out_b, lvl_b, e.out_a, e.lvl_a, e.out_b, e.lvl_b);
      end
    end
  endtask

  // Press ch0 for 10 cycles then release: rise pulse at edge 6, fall seen only by the both-edge copy.
  task automatic test_clean_press;
    exp_t e;
    for (int i = 1; i <= 20; i++)
      push_exp({1'b0, i == 6}, {1'b0, i >= 6 && i < 16},
               {1'b0, i == 6 || i == 16}, {1'b0, i >= 6 && i < 16});
    DataIn = 2'b01;
    for (int i = 1; i <= 20; i++) begin
      step;
      e = sb.pop_front();
      vectors++;
      if ({out_a, lvl_a, out_b, lvl_b} !== e) begin
        miscompares++;
        $display("FAIL clean_press edge %0d: got %b %b %b %b, expected %b %b %b %b", i,
                 out_a, lvl_a, out_b, lvl_b, e.out_a, e.lvl_a, e.out_b, e.lvl_b);
      end
      if (i == 10) DataIn = 2'b00;
    end
  endtask

  task automatic test_bounce;
    exp_t e;
    for (int i = 1; i <= 14; i++)
      push_exp({1'b0, i == 10}, {1'b0, i >= 10}, {1'b0, i == 10}, {1'b0, i >= 10});
    DataIn = 2'b01;
    for (int i = 1; i <= 14; i++) begin
      step;
      e = sb.pop_front();
      vectors++;
      if ({out_a, lvl_a, out_b, lvl_b} !== e) begin
        miscompares++;
        $display("FAIL bounce edge %0d: got %b %b %b %b, expected %b %b %b %b", i,
                 out_a, lvl_a, out_b, lvl_b, e.out_a, e.lvl_a, e.out_b, e.lvl_b);
      end
      if (i <= 4) DataIn = {1'b0, ~i[0]};
    end
    DataIn = 2'b00;
    repeat (12) step;
  endtask

  task automatic test_glitch;
    exp_t e;
    for (int i = 1; i <= 10; i++) push_exp(2'b00, 2'b00, 2'b00, 2'b00);
    DataIn = 2'b10;
    for (int i = 1; i <= 10; i++) begin
      step;
      e = sb.pop_front();
      vectors++;
      if ({out_a, lvl_a, out_b, lvl_b} !== e) begin
        miscompares++;
        $display("FAIL glitch edge %0d: got %b %b %b %b, expected %b %b %b %b", i,
                 out_a, lvl_a, out_b, lvl_b, e.out_a, e.lvl_a, e.out_b, e.lvl_b);
      end
      if (i == 3) DataIn = 2'b00;
    end
  endtask

  task automatic test_edge_both;
    exp_t e;
    for (int i = 1; i <= 20; i++)
      push_exp({2{i == 6}}, {2{i >= 6 && i < 16}},
               {2{i == 6 || i == 16}}, {2{i >= 6 && i < 16}});
    DataIn = 2'b11;
    for (int i = 1; i <= 20; i++) begin
      step;
      e = sb.pop_front();
      vectors++;
      if ({out_a, lvl_a, out_b, lvl_b} !== e) begin
        miscompares++;
        $display("FAIL edge_both edge %0d: got %b %b %b %b, expected %b %b %b %b", i,
                 out_a, lvl_a, out_b, lvl_b, e.out_a, e.lvl_a, e.out_b, e.lvl_b);
      end
      if (i == 10) DataIn = 2'b00;
    end
  endtask

  task automatic test_reset_mid_debounce;
    exp_t e;
    DataIn = 2'b10;
    repeat (8) step;
    vectors++;
    if ({lvl_a, lvl_b} !== 4'b1010) begin
      miscompares++;
      $display("FAIL precharge: got lvl_a=%b lvl_b=%b, expected 10 10", lvl_a, lvl_b);
    end
    DataIn = 2'b11;
    repeat (3) step;
    Reset = 1'b0;
    #1;
    push_exp(2'b00, 2'b00, 2'b00, 2'b00);
    e = sb.pop_front();
    vectors++;
    if ({out_a, lvl_a, out_b, lvl_b} !== e) begin
      miscompares++;
      $display("FAIL reset_async: got %b %b %b %b, expected %b %b %b %b",
               out_a, lvl_a, out_b, lvl_b, e.out_a, e.lvl_a, e.out_b, e.lvl_b);
    end
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    for (int i = 1; i <= 10; i++)
      push_exp({2{i == 6}}, {2{i >= 6}}, {2{i == 6}}, {2{i >= 6}});
    for (int i = 1; i <= 10; i++) begin
      step;
      e = sb.pop_front();
      vectors++;
      if ({out_a, lvl_a, out_b, lvl_b} !== e) begin
        miscompares++;
        $display("FAIL reset_release edge %0d: got %b %b %b %b, expected %b %b %b %b", i,
                 out_a, lvl_a, out_b, lvl_b, e.out_a, e.lvl_a, e.out_b, e.lvl_b);
      end
    end
    DataIn = 2'b00;
    repeat (12) step;
  endtask

`ifdef BUTTON_PULSER_REPEAT_EN
  // Accepted at edge 6; repeats at +8 then every 3; input dropped after +17 so no +20.
  task automatic test_repeat;
    exp_t e;
    logic rp;
    for (int i = 1; i <= 35; i++) begin
      rp = i == 6 || i == 14 || i == 17 || i == 20 || i == 23;
      push_exp({1'b0, rp}, {1'b0, i >= 6 && i < 29},
               {1'b0, rp || i == 29}, {1'b0, i >= 6 && i < 29});
    end
    DataIn = 2'b01;
    for (int i = 1; i <= 35; i++) begin
      step;
      e = sb.pop_front();
      vectors++;
      if ({out_a, lvl_a, out_b, lvl_b} !== e) begin
        miscompares++;
        $display("FAIL repeat edge %0d: got %b %b %b %b, expected %b %b %b %b", i,
                 out_a, lvl_a, out_b, lvl_b, e.out_a, e.lvl_a, e.out_b, e.lvl_b);
      end
      if (i == 23) DataIn = 2'b00;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_glitch;
    test_edge_both;
    test_reset_mid_debounce;
`ifdef BUTTON_PULSER_REPEAT_EN
    test_repeat;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
